// File: rtl/io_input_debounce.sv
// ---------------------------------------------------------------------------
// io_input_debounce
//
// Conditions the board inputs that the core reads through its load/store
// unit. Raw slide switches and push buttons are synchronised to i_clk,
// every button is debounced, and the block produces debounced button levels
// plus sticky press-event flags that the core clears per bit.
//
// Parameters
//   DB_CYCLES  cycles a synchronised input must differ from its stable value
//              before the stable value updates (legal 1..2**CNT_W)
//   CNT_W      width of each debounce counter
//
// Ports
//   i_clk      core clock, rising edge
//   i_rst      synchronous active-high reset
//   i_sw_raw   [31:0] raw switches, asynchronous, active-high
//   i_btn_raw  [3:0]  raw buttons, asynchronous, active-low (0 = pressed)
//   i_evt_clr  [3:0]  per-bit clear strobe for o_btn_evt
//   o_io_sw    [31:0] conditioned switch levels
//   o_io_btn   [3:0]  debounced button levels, active-high (1 = pressed)
//   o_btn_evt  [3:0]  sticky press flags, active-high
//
// Build option
//   IO_DEBOUNCE_SW_EN  when defined, every switch bit is debounced with the
//                      same rules as the buttons (no switch event flags).
//                      When undefined, switches are only synchronised.
// ---------------------------------------------------------------------------

// Per-bit debounce counter. The stable value itself lives in the parent so
// that the parent can register outputs and press events on the same edge the
// stable value changes; this cell only decides what the next stable value is.
module io_input_debounce_cnt #(
   parameter int unsigned DB_CYCLES = 500000,
   parameter int unsigned CNT_W     = 20
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_din,         // synchronised input bit
   input  logic i_stable,      // current stable value held by the parent
   output logic o_stable_nxt   // stable value after the coming edge
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_nxt      = '0;
      o_stable_nxt = i_stable;
      if (i_din != i_stable) begin
         if (cnt == CNT_LAST) begin
            // Input held long enough: accept it, count restarts from 0.
            o_stable_nxt = i_din;
         end else begin
            cnt_nxt = cnt + CNT_W'(1);
         end
      end
      // Any return to the stable value leaves cnt_nxt at 0, discarding a
      // partial count, so short pulses never reach CNT_LAST.
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

module io_input_debounce #(
   parameter int unsigned DB_CYCLES = 500000,
   parameter int unsigned CNT_W     = 20
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_sw_raw,
   input  logic [3:0]  i_btn_raw,
   input  logic [3:0]  i_evt_clr,
   output logic [31:0] o_io_sw,
   output logic [3:0]  o_io_btn,
   output logic [3:0]  o_btn_evt
);

   localparam int unsigned N_SW  = 32;
   localparam int unsigned N_BTN = 4;

   logic [N_SW-1:0]  sw_sync1;
   logic [N_SW-1:0]  sw_sync2;
   logic [N_BTN-1:0] btn_sync1;
   logic [N_BTN-1:0] btn_sync2;
   logic [N_BTN-1:0] btn_stable;
   logic [N_BTN-1:0] btn_stable_nxt;

   // Two-flop synchronisers. Buttons are active-low, so their flops reset to
   // the released level (1) and a held button cannot look like a fresh
   // transition out of reset.
   // NOTE: the synchroniser flops are reset deliberately so the debounce
   // logic sees a defined level on the first cycle after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sw_sync1  <= '0;
         sw_sync2  <= '0;
         btn_sync1 <= '1;
         btn_sync2 <= '1;
      end else begin
         sw_sync1  <= i_sw_raw;
         sw_sync2  <= sw_sync1;
         btn_sync1 <= i_btn_raw;
         btn_sync2 <= btn_sync1;
      end
   end

   for (genvar g = 0; g < N_BTN; g++) begin : g_btn
      io_input_debounce_cnt #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_cnt (
         .i_clk        (i_clk),
         .i_rst        (i_rst),
         .i_din        (btn_sync2[g]),
         .i_stable     (btn_stable[g]),
         .o_stable_nxt (btn_stable_nxt[g])
      );
   end

   // Stable value, level output and press flags all move on the same edge.
   // A press is stable going 1->0; it is OR-ed in after the clear so a press
   // and a clear on the same edge leave the flag set.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         btn_stable <= '1;
         o_io_btn   <= '0;
         o_btn_evt  <= '0;
      end else begin
         btn_stable <= btn_stable_nxt;
         o_io_btn   <= ~btn_stable_nxt;
         o_btn_evt  <= (btn_stable & ~btn_stable_nxt) | (o_btn_evt & ~i_evt_clr);
      end
   end

`ifdef IO_DEBOUNCE_SW_EN
   logic [N_SW-1:0] sw_stable;
   logic [N_SW-1:0] sw_stable_nxt;

   for (genvar g = 0; g < N_SW; g++) begin : g_sw
      io_input_debounce_cnt #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_cnt (
         .i_clk        (i_clk),
         .i_rst        (i_rst),
         .i_din        (sw_sync2[g]),
         .i_stable     (sw_stable[g]),
         .o_stable_nxt (sw_stable_nxt[g])
      );
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sw_stable <= '0;
      end else begin
         sw_stable <= sw_stable_nxt;
      end
   end

   assign o_io_sw = sw_stable;
`else
   assign o_io_sw = sw_sync2;
`endif

endmodule

// File: tb/tb_io_input_debounce.sv
// ---------------------------------------------------------------------------
// tb_io_input_debounce
//
// Self-checking bench for io_input_debounce with DB_CYCLES=8, CNT_W=4.
// A directed table of per-cycle vectors covers reset, clean press, glitch
// rejection, event clear and set/clear collision; hand-written sequences
// cover the switch path and reset in the middle of a count; a randomised
// phase is compared against a sliding-window reference model.
// ---------------------------------------------------------------------------
module tb_io_input_debounce;

   localparam int DB = 8;

   logic        i_clk;
   logic        i_rst;
   logic [31:0] i_sw_raw;
   logic [3:0]  i_btn_raw;
   logic [3:0]  i_evt_clr;
   logic [31:0] o_io_sw;
   logic [3:0]  o_io_btn;
   logic [3:0]  o_btn_evt;

   int n_checks = 0;
   int n_errors = 0;

   io_input_debounce #(
      .DB_CYCLES (DB),
      .CNT_W     (4)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_sw_raw  (i_sw_raw),
      .i_btn_raw (i_btn_raw),
      .i_evt_clr (i_evt_clr),
      .o_io_sw   (o_io_sw),
      .o_io_btn  (o_io_btn),
      .o_btn_evt (o_btn_evt)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // ------------------------------------------------------------------
   // Reference model. The synchronised value seen at an edge is the raw
   // value sampled two edges earlier; a stable bit flips when the last DB
   // synchronised samples all disagree with it.
   // ------------------------------------------------------------------
   localparam logic [35:0] RAW_RST = {32'h0, 4'hF};

   logic [35:0] raw_hist[$];
   logic [35:0] s_hist[$];
   logic [3:0]  m_btn_stable;
   logic [31:0] m_sw_stable;
   logic [3:0]  m_evt;
   logic [31:0] m_sw_out;

   function automatic logic window_flip(int idx, logic cur);
      if (s_hist.size() < DB) return 1'b0;
      foreach (s_hist[j]) if (s_hist[j][idx] == cur) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input logic rst, input logic [31:0] sw,
                             input logic [3:0] btn, input logic [3:0] clr);
      logic [35:0] s;
      logic        nst;
      if (rst) begin
         raw_hist.delete();
         raw_hist.push_back(RAW_RST);
         raw_hist.push_back(RAW_RST);
         s_hist.delete();
         m_btn_stable = 4'hF;
         m_sw_stable  = '0;
         m_evt        = '0;
         m_sw_out     = '0;
      end else begin
         raw_hist.push_back({sw, btn});
         s = raw_hist[raw_hist.size()-3];
         s_hist.push_back(s);
         if (s_hist.size() > DB) void'(s_hist.pop_front());
         for (int b = 0; b < 4; b++) begin
            nst = window_flip(b, m_btn_stable[b]) ? ~m_btn_stable[b] : m_btn_stable[b];
            m_evt[b] = (m_btn_stable[b] & ~nst) | (m_evt[b] & ~clr[b]);
            m_btn_stable[b] = nst;
         end
`ifdef IO_DEBOUNCE_SW_EN
         for (int b = 0; b < 32; b++) begin
            if (window_flip(b + 4, m_sw_stable[b])) m_sw_stable[b] = ~m_sw_stable[b];
         end
         m_sw_out = m_sw_stable;
`else
         m_sw_out = raw_hist[raw_hist.size()-2][35:4];
`endif
         while (raw_hist.size() > 3) void'(raw_hist.pop_front());
      end
   endtask

   // One clock edge: model follows the inputs present at the edge, outputs
   // are sampled 1 time unit later.
   task automatic tick();
      @(posedge i_clk);
      model_edge(i_rst, i_sw_raw, i_btn_raw, i_evt_clr);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Directed vector table: inputs held for n cycles, outputs compared
   // after every one of those cycles.
   // ------------------------------------------------------------------
   typedef struct {
      int         n;
      logic       rst;
      logic [3:0] btn;
      logic [3:0] clr;
      logic [3:0] exp_btn;
      logic [3:0] exp_evt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int n, input logic rst, input logic [3:0] btn,
                      input logic [3:0] clr, input logic [3:0] eb, input logic [3:0] ee);
      vec_t v;
      v.n = n; v.rst = rst; v.btn = btn; v.clr = clr; v.exp_btn = eb; v.exp_evt = ee;
      vecs.push_back(v);
   endtask

   logic [31:0] sw_val;
   logic [31:0] exp_sw;

   initial begin
      i_rst     = 1'b1;
      i_sw_raw  = '0;
      i_btn_raw = 4'hF;
      i_evt_clr = '0;
      raw_hist.push_back(RAW_RST);
      raw_hist.push_back(RAW_RST);
      m_btn_stable = 4'hF;
      m_sw_stable  = '0;
      m_evt        = '0;
      m_sw_out     = '0;

      //   n  rst btn   clr   exp_btn exp_evt
      add( 3, 1, 4'hF, 4'h0, 4'h0, 4'h0);   // reset, buttons released
      add(20, 0, 4'hF, 4'h0, 4'h0, 4'h0);   // quiet after reset
      add( 9, 0, 4'hE, 4'h0, 4'h0, 4'h0);   // clean press btn0: edges k..k+8
      add(11, 0, 4'hE, 4'h0, 4'h1, 4'h1);   // recognised at k+9
      add( 9, 0, 4'hF, 4'h0, 4'h1, 4'h1);   // release still debouncing
      add( 3, 0, 4'hF, 4'h0, 4'h0, 4'h1);   // released, flag stays
      add( 1, 0, 4'hF, 4'h1, 4'h0, 4'h0);   // clear btn0 flag
      add( 2, 0, 4'hF, 4'h0, 4'h0, 4'h0);
      add( 5, 0, 4'hD, 4'h0, 4'h0, 4'h0);   // 5-cycle glitch on btn1
      add(15, 0, 4'hF, 4'h0, 4'h0, 4'h0);   // rejected
      add( 9, 0, 4'hD, 4'h0, 4'h0, 4'h0);   // 12-cycle press btn1
      add( 3, 0, 4'hD, 4'h0, 4'h2, 4'h2);
      add( 9, 0, 4'hF, 4'h0, 4'h2, 4'h2);
      add( 1, 0, 4'hF, 4'h0, 4'h0, 4'h2);
      add( 9, 0, 4'hB, 4'h0, 4'h0, 4'h2);   // press btn2
      add( 3, 0, 4'hB, 4'h0, 4'h4, 4'h6);
      add( 1, 0, 4'hB, 4'h4, 4'h4, 4'h2);   // one-cycle clear of btn2
      add( 1, 0, 4'hB, 4'h0, 4'h4, 4'h2);
      add( 9, 0, 4'hF, 4'h0, 4'h4, 4'h2);
      add( 1, 0, 4'hF, 4'h0, 4'h0, 4'h2);
      add( 9, 0, 4'h7, 4'h0, 4'h0, 4'h2);   // press btn3
      add( 1, 0, 4'h7, 4'h8, 4'h8, 4'hA);   // clear on the press edge: set wins
      add( 2, 0, 4'h7, 4'h0, 4'h8, 4'hA);
      add( 1, 0, 4'h7, 4'hF, 4'h8, 4'h0);   // clear all
      add( 9, 0, 4'hF, 4'h0, 4'h8, 4'h0);
      add( 1, 0, 4'hF, 4'h0, 4'h0, 4'h0);

      foreach (vecs[i]) begin
         i_rst     = vecs[i].rst;
         i_btn_raw = vecs[i].btn;
         i_evt_clr = vecs[i].clr;
         i_sw_raw  = '0;
         for (int c = 0; c < vecs[i].n; c++) begin
            tick();
            check($sformatf("vec%0d.%0d btn", i, c), {28'h0, o_io_btn}, {28'h0, vecs[i].exp_btn});
            check($sformatf("vec%0d.%0d evt", i, c), {28'h0, o_btn_evt}, {28'h0, vecs[i].exp_evt});
            check($sformatf("vec%0d.%0d sw", i, c), o_io_sw, 32'h0);
         end
      end
      i_evt_clr = '0;

      // Reset in the middle of a count: btn0 pressed, reset after count 5.
      i_btn_raw = 4'hE;
      for (int c = 0; c < 7; c++) begin
         tick();
         check($sformatf("midrst pre%0d btn", c), {28'h0, o_io_btn}, 32'h0);
      end
      i_rst = 1'b1;
      tick();
      check("midrst rst btn", {28'h0, o_io_btn}, 32'h0);
      check("midrst rst evt", {28'h0, o_btn_evt}, 32'h0);
      i_rst = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         check($sformatf("midrst post%0d btn", c), {28'h0, o_io_btn}, (c == 10) ? 32'h1 : 32'h0);
         check($sformatf("midrst post%0d evt", c), {28'h0, o_btn_evt}, (c == 10) ? 32'h1 : 32'h0);
      end
      i_btn_raw = 4'hF;
      i_evt_clr = 4'h1;
      tick();
      i_evt_clr = 4'h0;

      // Switch path.
      sw_val   = 32'hA5A5_0F0F;
      i_sw_raw = sw_val;
`ifdef IO_DEBOUNCE_SW_EN
      for (int c = 0; c < 10; c++) begin
         tick();
         check($sformatf("sw settle%0d", c), o_io_sw, (c == 9) ? sw_val : 32'h0);
      end
      i_sw_raw = sw_val ^ 32'h1;
      for (int c = 0; c < 15; c++) begin
         if (c == 3) i_sw_raw = sw_val;
         tick();
         check($sformatf("sw pulse%0d", c), o_io_sw, sw_val);
      end
`else
      for (int c = 0; c < 2; c++) begin
         tick();
         check($sformatf("sw settle%0d", c), o_io_sw, (c == 1) ? sw_val : 32'h0);
      end
      i_sw_raw = sw_val ^ 32'h1;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) i_sw_raw = sw_val;
         tick();
         exp_sw = (c >= 1 && c <= 3) ? (sw_val ^ 32'h1) : sw_val;
         check($sformatf("sw pulse%0d", c), o_io_sw, exp_sw);
      end
`endif

      // Randomised phase against the reference model.
      for (int c = 0; c < 2500; c++) begin
         i_rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 5) == 0) i_btn_raw = i_btn_raw ^ (4'h1 << $urandom_range(0, 3));
         i_evt_clr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 49) == 0) i_sw_raw = $urandom;
         else if ($urandom_range(0, 9) == 0) i_sw_raw = i_sw_raw ^ (32'h1 << $urandom_range(0, 31));
         tick();
         check($sformatf("rand%0d btn", c), {28'h0, o_io_btn}, {28'h0, ~m_btn_stable});
         check($sformatf("rand%0d evt", c), {28'h0, o_btn_evt}, {28'h0, m_evt});
         check($sformatf("rand%0d sw", c), o_io_sw, m_sw_out);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/io_input_debounce.md
# io_input_debounce

Front-end conditioning stage for the board inputs that the single-cycle core reads through its load/store unit. It synchronises the raw switch and push-button pins to the core clock, debounces every button, and produces debounced levels plus sticky press-event flags. Its outputs drive the core's switch and button input ports directly. Event flags are cleared by the core through a per-bit clear strobe.

## Interface
- DB_CYCLES, 500000: cycles a synchronised input must differ from its stable value before the stable value updates (10 ms at 50 MHz); legal range 1..2^CNT_W.
- CNT_W, 20: width of each debounce counter.

- i_clk  in  1  core clock; all logic on the rising edge.
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_sw_raw  in  32  raw slide switches, asynchronous, active-high.
- i_btn_raw  in  4  raw push buttons, asynchronous, active-low (0 = pressed).
- i_evt_clr  in  4  per-bit clear strobe for o_btn_evt, synchronous to i_clk.
- o_io_sw  out  32  conditioned switch levels; feeds i_io_sw.
- o_io_btn  out  4  debounced button levels, active-high (1 = pressed); feeds i_io_btn.
- o_btn_evt  out  4  sticky press flags, active-high.

## Operation
- Synchroniser: 2 flops per input bit (sync1, sync2). Button flops reset to 1 (released); switch flops reset to 0.
- Button debounce, per bit: keeps a stable value and a counter.
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DB_CYCLES-1: stable <= sync2 and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any return to the stable value before the count completes restarts the count from 0. Pulses shorter than DB_CYCLES are fully rejected.
- Output mapping:
  - o_io_btn[i] = ~stable[i], registered.
  - o_io_sw = sync2, unless SW debounce is compiled in (see Configuration).
- Press events, per bit: o_btn_evt[i] is set on the edge where stable[i] goes 1→0 (press). It is cleared on the edge after i_evt_clr[i]=1.
  - Set and clear on the same edge: set wins.
  - Releases never set a flag.
- Counters never wrap. The count is bounded by DB_CYCLES-1 ≤ 2^CNT_W-1.
- Bits are independent. Simultaneous activity on several bits is handled in parallel with no priority.

## Timing
- Reset values: o_io_sw=0, o_io_btn=0, o_btn_evt=0, all counters 0, button stable=1 (released). No event is generated when reset deasserts while a button is held; the press is recognised after the normal debounce latency.
- Raw change first sampled into sync1 at edge k:
  - sync2 holds the change at edge k+1.
  - stable, o_io_btn and o_btn_evt update at edge k+1+DB_CYCLES, provided the input is held throughout.
- Switch path without the macro: o_io_sw reflects a change at edge k+1 (2-cycle latency).
- Clear latency: o_btn_evt[i] reads 0 one edge after the i_evt_clr[i] pulse.
- Reset asserted mid-count: counters go to 0, stable goes to released, flags are cleared on that edge. An in-progress debounce is discarded.

## Configuration
- IO_DEBOUNCE_SW_EN defined: every switch bit gets its own stable register and DB_CYCLES counter, with the same rules as the buttons.
  - Stable resets to 0; o_io_sw = stable.
  - Latency is edge k+1+DB_CYCLES.
  - No event flags are generated for switches.
- Not defined: switches are only synchronised, with no switch counters instantiated.

## Test plan
All scenarios use DB_CYCLES=8, CNT_W=4.
- Reset: i_rst=1 for 3 cycles with i_btn_raw=4'hF, i_sw_raw=0 → o_io_sw=0, o_io_btn=0, o_btn_evt=0. Outputs stay 0 for 20 cycles after release.
- Clean press: i_btn_raw[0] 1→0 first sampled at edge k and held for 20 cycles → o_io_btn[0]=1 and o_btn_evt[0]=1 at edge k+9, not before.
- Glitch: i_btn_raw[1] low for 5 cycles, then high → o_io_btn[1] and o_btn_evt[1] stay 0. A subsequent 12-cycle press is recognised at edge k+9 of that press.
- Event clear and collision:
  - With o_btn_evt[2]=1, a one-cycle i_evt_clr[2] pulse → 0 next edge.
  - A clear pulse on the same edge as a new press of button 3 → o_btn_evt[3]=1.
- Switches: i_sw_raw=32'hA5A5_0F0F sampled at edge k:
  - Without IO_DEBOUNCE_SW_EN → o_io_sw=32'hA5A5_0F0F at edge k+1.
  - With IO_DEBOUNCE_SW_EN → same value at edge k+9, and a 3-cycle pulse on bit 0 is rejected.
- Reset mid-count: press button 0, assert i_rst at count 5 → counter 0, o_io_btn[0]=0. After release of i_rst with the button still held, o_io_btn[0]=1 a full 10 edges later.
